alu_ctrl: RTL and testbench
===========================

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have port start  in  1  command request, sampled only in IDLE.
REQ-004 SHALL have port op  in  3  command: 000 LDA, 001 LDB, 010 ADD, 011 SUB, 100 AND, 101 NOT, 110 MUL, 111 illegal.
REQ-005 SHALL have port din  in  8  operand for LDA/LDB.
REQ-006 SHALL have ports alu_m out 1, alu_s out 4, alu_a out 8, alu_b out 8, which drive the team ALU.
REQ-007 SHALL have ports alu_t in 8, alu_cf in 1, alu_zf in 1, which are combinational ALU results.
REQ-008 SHALL have ports acc out 8 (A register), breg out 8 (B register), cf out 1, zf out 1 (registered flags).
REQ-009 SHALL have ports busy out 1, done out 1 (one-cycle pulse), err out 1 (pulses with done on illegal op).

Function
REQ-010 SHALL use FSM states IDLE, EXEC, MUL, DONE; busy=1 in every state except IDLE.
REQ-011 SHALL accept start only in IDLE: op and din are latched at edge k, and the FSM enters EXEC (or MUL for op 110).
REQ-012 SHALL ignore start in EXEC/MUL/DONE, with no queueing.
REQ-013 SHALL drive ALU in EXEC as follows: LDA m=0 s=1100 a=din; LDB m=1 s=1010 b=din; ADD m=1 s=1001 a=A b=B; SUB m=1 s=0110 a=A b=B; AND m=1 s=1011; NOT m=1 s=0101 b=B.
REQ-014 SHALL, at the edge ending EXEC, write alu_t to A (B for LDB), set cf/zf from alu_cf/alu_zf for every legal op, and enter DONE.
REQ-015 SHALL, for op 111, skip the ALU drive, leave A/B/cf/zf unchanged, and pulse err with done.
REQ-016 SHALL run MUL as follows: on entry P=0 and cnt=B; each MUL cycle with cnt!=0 drives m=1 s=1001 a=P b=A, sets P=alu_t, cf|=alu_cf, and cnt-=1.
REQ-017 SHALL, in a MUL cycle with cnt==0, write A=P, set zf=(P==0), and enter DONE; the MUL state therefore lasts B+1 cycles, and B=0 gives A=0, zf=1, cf=0.
REQ-018 SHALL compute MUL results mod 256, with cf=1 if any partial sum overflowed.
REQ-019 SHALL hold done=1 for exactly the single DONE cycle, then return to IDLE; DONE is entered at edge k+1 (single op) or k+B+1 (MUL).
REQ-020 SHALL drive alu_m=0, alu_s=0, alu_a=0, alu_b=0 in IDLE and DONE.

Reset
REQ-021 SHALL, with rst=1 at an edge, force IDLE; A, B, P, cnt, cf, zf = 0; done=err=busy=0.
REQ-022 SHALL give rst priority over start and abort any in-progress EXEC/MUL without a done pulse.

Configuration
REQ-023 SHALL, with macro ALU_CTRL_MUL_EN defined, implement MUL per REQ-016..018.
REQ-024 SHALL, without ALU_CTRL_MUL_EN, treat op 110 as illegal per REQ-015 and omit the MUL state, P and cnt from the RTL.

Structure
REQ-025 SHALL place op encodings, FSM state encodings, and ALU m/s code constants in shared package alu_ctrl_pkg.
REQ-026 SHALL implement the FSM state register and next-state logic in sub-module alu_ctrl_fsm, with the datapath in alu_ctrl.
REQ-027 SHALL keep the ALU external and connect it at the next level up.

Verification
REQ-028 SHALL verify: reset, then LDA din=0x0F, then LDB din=0xF3, then ADD -> acc=0x02, cf=1, zf=0, done 1 edge after EXEC.
REQ-029 SHALL verify: A=0x05, B=0x05, SUB -> acc=0x00, zf=1, cf=0; A=0x06, B=0x05, SUB -> acc=0xFF, cf=1.
REQ-030 SHALL verify with ALU_CTRL_MUL_EN defined: A=0x07, B=0x03, MUL -> acc=0x15, cf=0, busy for 5 cycles; A=0x80, B=0x02 -> acc=0x00, zf=1, cf=1; B=0 -> acc=0, zf=1.
REQ-031 SHALL verify: op=111 -> done+err pulse together, with A, B and flags unchanged; without ALU_CTRL_MUL_EN, op=110 behaves identically.
REQ-032 SHALL verify: start held high during MUL -> ignored, with exactly one done per accepted command.
REQ-033 SHALL verify: rst asserted mid-MUL (A=3, B=10, cycle 4) -> next cycle IDLE, all registers 0, no done.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU controller: command encodings, FSM state
// encodings and the m/s codes presented to the external team ALU.
// Optional feature macro: ALU_CTRL_MUL_EN (multi-cycle shift-free MUL).
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_LDA = 3'b000,
    OP_LDB = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_AND = 3'b100,
    OP_NOT = 3'b101,
    OP_MUL = 3'b110,
    OP_ILL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
`ifdef ALU_CTRL_MUL_EN
    ST_MUL  = 2'd2,
`endif
    ST_DONE = 2'd3
  } state_e;

  // Mode bit and function select for one ALU operation.
  typedef struct packed {
    logic       m;
    logic [3:0] s;
  } alu_code_t;

  localparam alu_code_t ALU_NOP = '{m: 1'b0, s: 4'b0000};
  localparam alu_code_t ALU_LDA = '{m: 1'b0, s: 4'b1100};
  localparam alu_code_t ALU_LDB = '{m: 1'b1, s: 4'b1010};
  localparam alu_code_t ALU_ADD = '{m: 1'b1, s: 4'b1001};
  localparam alu_code_t ALU_SUB = '{m: 1'b1, s: 4'b0110};
  localparam alu_code_t ALU_AND = '{m: 1'b1, s: 4'b1011};
  localparam alu_code_t ALU_NOT = '{m: 1'b1, s: 4'b0101};

  // An op is legal when this build can execute it; MUL is only legal
  // when the multiplier is compiled in.
  function automatic logic op_legal(input op_e o);
`ifdef ALU_CTRL_MUL_EN
    return (o != OP_ILL);
`else
    return !((o == OP_MUL) || (o == OP_ILL));
`endif
  endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Bus between the controller and the external combinational team ALU.
// The controller (master) presents m/s/a/b; the ALU (slave) answers with
// t/cf/zf in the same cycle.
interface alu_ctrl_if;
  logic       alu_m;
  logic [3:0] alu_s;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_t;
  logic       alu_cf;
  logic       alu_zf;

  modport master (
    output alu_m, alu_s, alu_a, alu_b,
    input  alu_t, alu_cf, alu_zf
  );

  modport slave (
    input  alu_m, alu_s, alu_a, alu_b,
    output alu_t, alu_cf, alu_zf
  );
endinterface

// File: rtl/alu_ctrl_fsm.sv
// Control FSM of the ALU controller: IDLE -> EXEC (or MUL) -> DONE -> IDLE.
// The current state is exported so the datapath and any checker can see it.
// With ALU_CTRL_MUL_EN the MUL state and its exit condition are present.
module alu_ctrl_fsm
  import alu_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
`ifdef ALU_CTRL_MUL_EN
  input  op_e    op,
  input  logic   mul_last,
`endif
  input  logic   start,
  output state_e state
);

  state_e state_q;
  state_e state_d;

  assign state = state_q;

  // State register with synchronous reset to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only looked at while idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef ALU_CTRL_MUL_EN
          state_d = (op == OP_MUL) ? ST_MUL : ST_EXEC;
`else
          state_d = ST_EXEC;
`endif
        end
      end
      ST_EXEC: state_d = ST_DONE;
`ifdef ALU_CTRL_MUL_EN
      ST_MUL:  if (mul_last) state_d = ST_DONE;
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// ALU controller top: latches a command, sequences the external ALU and
// keeps the A/B registers and cf/zf flags.
// Optional feature macro: ALU_CTRL_MUL_EN adds repeated-addition MUL.
//
// Command handshake: start is sampled only while busy is low; the command
// (op, din) is captured on that edge. busy stays high until the command
// completes, and done (with err for an illegal op) pulses for exactly one
// cycle at completion. start while busy is dropped, never queued.
module alu_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [7:0]        din,
  alu_ctrl_if.master        alu_bus,
  output logic [7:0]        acc,
  output logic [7:0]        breg,
  output logic              cf,
  output logic              zf,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e    state;
  op_e       op_q;
  logic [7:0] din_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       cf_q;
  logic       zf_q;
  alu_code_t  code;
  logic [7:0] a_drv;
  logic [7:0] b_drv;

`ifdef ALU_CTRL_MUL_EN
  logic [7:0] p_q;
  logic [7:0] cnt_q;
  logic       mul_last;

  assign mul_last = (cnt_q == 8'd0);
`endif

  alu_ctrl_fsm u_fsm (
    .clk      (clk),
    .rst      (rst),
`ifdef ALU_CTRL_MUL_EN
    .op       (op_e'(op)),
    .mul_last (mul_last),
`endif
    .start    (start),
    .state    (state)
  );

  // ALU drive: idle/done cycles and illegal ops present all-zero codes.
  always_comb begin
    code  = ALU_NOP;
    a_drv = 8'd0;
    b_drv = 8'd0;
    case (state)
      ST_EXEC: begin
        case (op_q)
          OP_LDA: begin code = ALU_LDA; a_drv = din_q; end
          OP_LDB: begin code = ALU_LDB; b_drv = din_q; end
          OP_ADD: begin code = ALU_ADD; a_drv = a_q; b_drv = b_q; end
          OP_SUB: begin code = ALU_SUB; a_drv = a_q; b_drv = b_q; end
          OP_AND: begin code = ALU_AND; a_drv = a_q; b_drv = b_q; end
          OP_NOT: begin code = ALU_NOT; b_drv = b_q; end
          default: ;
        endcase
      end
`ifdef ALU_CTRL_MUL_EN
      // One partial sum P + A per cycle while iterations remain.
      ST_MUL: begin
        if (!mul_last) begin
          code  = ALU_ADD;
          a_drv = p_q;
          b_drv = a_q;
        end
      end
`endif
      default: ;
    endcase
  end

  assign alu_bus.alu_m = code.m;
  assign alu_bus.alu_s = code.s;
  assign alu_bus.alu_a = a_drv;
  assign alu_bus.alu_b = b_drv;

  // Datapath registers: command capture, result write-back and MUL loop.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= OP_LDA;
      din_q <= 8'd0;
      a_q   <= 8'd0;
      b_q   <= 8'd0;
      cf_q  <= 1'b0;
      zf_q  <= 1'b0;
`ifdef ALU_CTRL_MUL_EN
      p_q   <= 8'd0;
      cnt_q <= 8'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= op_e'(op);
            din_q <= din;
`ifdef ALU_CTRL_MUL_EN
            // MUL starts from a clean accumulator and carry.
            if (op_e'(op) == OP_MUL) begin
              p_q   <= 8'd0;
              cnt_q <= b_q;
              cf_q  <= 1'b0;
            end
`endif
          end
        end
        ST_EXEC: begin
          if (op_legal(op_q)) begin
            cf_q <= alu_bus.alu_cf;
            zf_q <= alu_bus.alu_zf;
            if (op_q == OP_LDB) begin
              b_q <= alu_bus.alu_t;
            end else begin
              a_q <= alu_bus.alu_t;
            end
          end
        end
`ifdef ALU_CTRL_MUL_EN
        ST_MUL: begin
          if (!mul_last) begin
            p_q   <= alu_bus.alu_t;
            cf_q  <= cf_q | alu_bus.alu_cf;
            cnt_q <= cnt_q - 8'd1;
          end else begin
            a_q  <= p_q;
            zf_q <= (p_q == 8'd0);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign acc  = a_q;
  assign breg = b_q;
  assign cf   = cf_q;
  assign zf   = zf_q;
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);
  assign err  = (state == ST_DONE) && !op_legal(op_q);

endmodule

// File: tb/tb_alu_ctrl.sv
// Testbench for alu_ctrl. Provides a behavioural team ALU on the bus,
// a reference model of A/B/cf/zf and a scoreboard queue of expected
// {acc, breg, cf, zf, err} values checked on each done pulse.
module tb_alu_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [7:0] din;
  logic [7:0] acc;
  logic [7:0] breg;
  logic       cf;
  logic       zf;
  logic       busy;
  logic       done;
  logic       err;

  alu_ctrl_if alu_bus ();

  alu_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .din     (din),
    .alu_bus (alu_bus),
    .acc     (acc),
    .breg    (breg),
    .cf      (cf),
    .zf      (zf),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- team ALU model ----------------
  // SUB (s=0110) yields b - a with cf as borrow (a > b).
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum        = {1'b0, alu_bus.alu_a} + {1'b0, alu_bus.alu_b};
    alu_bus.alu_t  = 8'd0;
    alu_bus.alu_cf = 1'b0;
    case ({alu_bus.alu_m, alu_bus.alu_s})
      5'b0_1100: alu_bus.alu_t = alu_bus.alu_a;
      5'b1_1010: alu_bus.alu_t = alu_bus.alu_b;
      5'b1_1001: begin
        alu_bus.alu_t  = alu_sum[7:0];
        alu_bus.alu_cf = alu_sum[8];
      end
      5'b1_0110: begin
        alu_bus.alu_t  = alu_bus.alu_b - alu_bus.alu_a;
        alu_bus.alu_cf = (alu_bus.alu_a > alu_bus.alu_b);
      end
      5'b1_1011: alu_bus.alu_t = alu_bus.alu_a & alu_bus.alu_b;
      5'b1_0101: alu_bus.alu_t = ~alu_bus.alu_b;
      default:   alu_bus.alu_t = 8'd0;
    endcase
    alu_bus.alu_zf = (alu_bus.alu_t == 8'd0);
  end

  // ---------------- scoreboard / model ----------------
  logic [18:0] exp_q[$];
  logic [7:0]  m_a, m_b;
  logic        m_cf, m_zf;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic model_reset();
    m_a = 8'd0; m_b = 8'd0; m_cf = 1'b0; m_zf = 1'b0;
  endtask

  // Applies one command to the model, pushes the expected outcome and
  // returns how many cycles busy should be high.
  task automatic model_push(input logic [2:0] c_op, input logic [7:0] c_din,
                            output int exp_busy);
    logic [8:0] sum;
    logic [7:0] p;
    logic       c;
    logic       e;
    e = 1'b0;
    exp_busy = 2;
    case (c_op)
      3'b000: begin m_a = c_din; m_cf = 1'b0; m_zf = (c_din == 8'd0); end
      3'b001: begin m_b = c_din; m_cf = 1'b0; m_zf = (c_din == 8'd0); end
      3'b010: begin
        sum = {1'b0, m_a} + {1'b0, m_b};
        m_a = sum[7:0]; m_cf = sum[8]; m_zf = (sum[7:0] == 8'd0);
      end
      3'b011: begin
        m_cf = (m_a > m_b);
        m_a  = m_b - m_a;
        m_zf = (m_a == 8'd0);
      end
      3'b100: begin m_a = m_a & m_b; m_cf = 1'b0; m_zf = (m_a == 8'd0); end
      3'b101: begin m_a = ~m_b; m_cf = 1'b0; m_zf = (m_a == 8'd0); end
`ifdef ALU_CTRL_MUL_EN
      3'b110: begin
        p = 8'd0; c = 1'b0;
        for (int i = 0; i < int'(m_b); i++) begin
          sum = {1'b0, p} + {1'b0, m_a};
          p = sum[7:0];
          c = c | sum[8];
        end
        m_a = p; m_cf = c; m_zf = (p == 8'd0);
        exp_busy = int'(m_b) + 2;
      end
`endif
      default: e = 1'b1;
    endcase
    exp_q.push_back({m_a, m_b, m_cf, m_zf, e});
  endtask

  // ---------------- driver ----------------
  task automatic run_cmd(input string name, input logic [2:0] c_op,
                         input logic [7:0] c_din, input bit hold);
    int          exp_busy;
    int          busy_n;
    bit          seen;
    logic [18:0] exp_v;
    logic [18:0] got;
    model_push(c_op, c_din, exp_busy);
    @(negedge clk);
    start = 1'b1; op = c_op; din = c_din;
    @(posedge clk);
    busy_n = 0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        seen  = 1'b1;
        start = 1'b0;
        got   = {acc, breg, cf, zf, err};
        exp_v = exp_q.pop_front();
        n_checks++;
        if (got !== exp_v) begin
          n_errors++;
          $display("FAIL %s result {acc,breg,cf,zf,err}: got %h expected %h",
                   name, got, exp_v);
        end
      end
    end
    start = 1'b0;
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s done_timeout: got no done, expected done", name);
      void'(exp_q.pop_front());
    end
    n_checks++;
    if (busy_n !== exp_busy) begin
      n_errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_n, exp_busy);
    end
    @(negedge clk);
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_errors++;
      $display("FAIL %s after_done {done,busy}: got %b expected 00", name, {done, busy});
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b1; op = 3'b000; din = 8'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({acc, breg, cf, zf, busy, done, err} !== 21'd0) begin
      n_errors++;
      $display("FAIL reset outputs: got %h expected 0",
               {acc, breg, cf, zf, busy, done, err});
    end
    n_checks++;
    if ({alu_bus.alu_m, alu_bus.alu_s, alu_bus.alu_a, alu_bus.alu_b} !== 21'd0) begin
      n_errors++;
      $display("FAIL reset alu_drive: got %h expected 0",
               {alu_bus.alu_m, alu_bus.alu_s, alu_bus.alu_a, alu_bus.alu_b});
    end
    rst = 1'b0; start = 1'b0;
    model_reset();
  endtask

  task automatic test_add();
    run_cmd("lda_0f", 3'b000, 8'h0F, 1'b0);
    run_cmd("ldb_f3", 3'b001, 8'hF3, 1'b0);
    run_cmd("add",    3'b010, 8'h00, 1'b0);
  endtask

  task automatic test_sub();
    run_cmd("lda_05",   3'b000, 8'h05, 1'b0);
    run_cmd("ldb_05",   3'b001, 8'h05, 1'b0);
    run_cmd("sub_zero", 3'b011, 8'h00, 1'b0);
    run_cmd("lda_06",   3'b000, 8'h06, 1'b0);
    run_cmd("sub_neg",  3'b011, 8'h00, 1'b0);
  endtask

  task automatic test_logic();
    run_cmd("lda_rnd", 3'b000, 8'($urandom_range(0, 255)), 1'b0);
    run_cmd("ldb_rnd", 3'b001, 8'($urandom_range(0, 255)), 1'b0);
    run_cmd("and",     3'b100, 8'h00, 1'b0);
    run_cmd("not",     3'b101, 8'h00, 1'b0);
    run_cmd("ldb_ff",  3'b001, 8'hFF, 1'b0);
    run_cmd("not_ff",  3'b101, 8'h00, 1'b0);
  endtask

  task automatic test_illegal();
    run_cmd("lda_a5",  3'b000, 8'hA5, 1'b0);
    run_cmd("ldb_3c",  3'b001, 8'h3C, 1'b0);
    run_cmd("add_pre", 3'b010, 8'h00, 1'b0);
    run_cmd("op_111",  3'b111, 8'h77, 1'b0);
`ifndef ALU_CTRL_MUL_EN
    run_cmd("op_110_disabled", 3'b110, 8'h11, 1'b0);
`endif
  endtask

`ifdef ALU_CTRL_MUL_EN
  task automatic test_mul();
    run_cmd("lda_07",   3'b000, 8'h07, 1'b0);
    run_cmd("ldb_03",   3'b001, 8'h03, 1'b0);
    run_cmd("mul_7x3",  3'b110, 8'h00, 1'b0);
    run_cmd("lda_80",   3'b000, 8'h80, 1'b0);
    run_cmd("ldb_02",   3'b001, 8'h02, 1'b0);
    run_cmd("mul_ovf",  3'b110, 8'h00, 1'b0);
    run_cmd("lda_09",   3'b000, 8'h09, 1'b0);
    run_cmd("ldb_00",   3'b001, 8'h00, 1'b0);
    run_cmd("mul_b0",   3'b110, 8'h00, 1'b0);
  endtask
`endif

  task automatic test_start_held();
    run_cmd("held_lda", 3'b000, 8'h07, 1'b0);
    run_cmd("held_ldb", 3'b001, 8'h03, 1'b0);
`ifdef ALU_CTRL_MUL_EN
    run_cmd("held_mul", 3'b110, 8'h00, 1'b1);
`else
    run_cmd("held_add", 3'b010, 8'h00, 1'b1);
`endif
  endtask

  task automatic test_reset_abort();
    bit saw_done;
    run_cmd("abort_lda", 3'b000, 8'h03, 1'b0);
    run_cmd("abort_ldb", 3'b001, 8'h0A, 1'b0);
    @(negedge clk);
    start = 1'b1; din = 8'h00;
`ifdef ALU_CTRL_MUL_EN
    op = 3'b110;
`else
    op = 3'b010;
`endif
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
`ifdef ALU_CTRL_MUL_EN
    repeat (3) @(negedge clk);
`endif
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({acc, breg, cf, zf, busy, done, err} !== 21'd0) begin
      n_errors++;
      $display("FAIL reset_abort state: got %h expected 0",
               {acc, breg, cf, zf, busy, done, err});
    end
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_abort late_activity: got done/busy after reset, expected none");
    end
    model_reset();
  endtask

  task automatic test_back_to_back();
    logic [2:0] r_op;
    for (int i = 0; i < 10; i++) begin
      r_op = 3'($urandom_range(0, 7));
      run_cmd("rand", r_op, 8'($urandom_range(0, 255)), 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'b000; din = 8'h00;
    model_reset();
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_illegal();
`ifdef ALU_CTRL_MUL_EN
    test_mul();
`endif
    test_start_held();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
